toy_accel: RTL and testbench

Single-lane toy accelerator that consumes the `{action, data}` command stream the G-QED harness drives and produces the matching response stream. It is the responder end of the harness's command interface: commands either load the architectural state or compute a result against it. A 3-stage pipeline feeds a 2-entry output buffer, and backpressure runs from `out_rdy` through to `in_rdy`. The architectural state is exported so that harness copies can compare it.

---
 rtl/toy_accel_pkg.sv | 21 ++
 rtl/toy_obuf.sv | 70 +++++++
 rtl/toy_accel.sv | 106 ++++++++++
 tb/tb_toy_accel.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/toy_accel_pkg.sv
// Shared types and constants for the toy accelerator: command encoding and
// the pipeline stage record.
package toy_accel_pkg;

   localparam int DATA_W = 2;

   localparam logic ACT_LOAD = 1'b1;
   localparam logic ACT_COMP = 1'b0;

   typedef struct packed {
      logic              vld;
      logic              action;
      logic [DATA_W-1:0] data;
   } stage_t;

   // Occupancy counter width for a FIFO holding 0..depth entries.
   function automatic int count_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage : toy_accel_pkg

// File: rtl/toy_obuf.sv
// Parameterized response FIFO. Push and pop may coincide at any occupancy,
// including full, where the freed head slot is reused by the incoming entry.
module toy_obuf
   import toy_accel_pkg::*;
#(
   parameter  int DEPTH = 2,
   parameter  int WIDTH = 2,
   localparam int CNT_W = count_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count,
   output logic [WIDTH-1:0] head
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   always_comb begin
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         if (do_push) begin
            wr_ptr <= next_ptr(wr_ptr);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: entries are only observable while counted.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

endmodule : toy_obuf

// File: rtl/toy_accel.sv
// Single-lane toy accelerator: three-stage uniform-shift pipeline retiring
// load/compute commands against one accumulator into a response FIFO.
module toy_accel
   import toy_accel_pkg::*;
#(
   parameter int DATA_W     = toy_accel_pkg::DATA_W,
   parameter int OBUF_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_vld,
   output logic              in_rdy,
   input  logic              action,
   input  logic [DATA_W-1:0] data,
   output logic              out_vld,
   input  logic              out_rdy,
   output logic [DATA_W-1:0] out,
   output logic [DATA_W-1:0] arch_st,
   output logic              busy
);

   localparam int CNT_W = count_width(OBUF_DEPTH);

   // Same layout as stage_t, sized by this instance's DATA_W.
   typedef struct packed {
      logic              vld;
      logic              action;
      logic [DATA_W-1:0] data;
   } lane_t;

   // Handshakes: a transfer happens on a rising edge where valid && ready;
   // valid never waits on ready, and in_rdy may depend combinationally on out_rdy.

   lane_t             s0;
   lane_t             s1;
   lane_t             s2;
   logic [DATA_W-1:0] acc;

   logic              advance;
   logic              retire;
   logic              push;
   logic [DATA_W-1:0] push_data;
   logic              pop;

   logic              obuf_full;
   logic              obuf_empty;
   logic [CNT_W-1:0]  obuf_count;
   logic [DATA_W-1:0] obuf_head;

   // Uniform stall: only a compute in S2 facing a full, non-draining buffer blocks.
   always_comb begin
      pop       = out_vld && out_rdy;
      advance   = !s2.vld || (s2.action == ACT_LOAD) || !obuf_full || pop;
      retire    = advance && s2.vld;
      push      = retire && (s2.action == ACT_COMP);
      push_data = s2.data + acc;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0 <= '0;
         s1 <= '0;
         s2 <= '0;
      end else if (advance) begin
         s0 <= '{vld: in_vld, action: action, data: data};
         s1 <= s0;
         s2 <= s1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (retire) begin
         if (s2.action == ACT_LOAD) begin
            acc <= s2.data;
         end else begin
            acc <= acc + 1'b1;
         end
      end
   end

   toy_obuf #(
      .DEPTH (OBUF_DEPTH),
      .WIDTH (DATA_W)
   ) u_obuf (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .full      (obuf_full),
      .empty     (obuf_empty),
      .count     (obuf_count),
      .head      (obuf_head)
   );

   always_comb begin
      in_rdy  = advance;
      out_vld = !obuf_empty;
      out     = obuf_empty ? '0 : obuf_head;
      arch_st = acc;
      busy    = s0.vld || s1.vld || s2.vld || (obuf_count != '0);
   end

endmodule : toy_accel

// File: tb/tb_toy_accel.sv
// Bench for toy_accel: directed table, stall/backpressure sequences, reset
// mid-flight, and random traffic scored against an in-order command model.
module tb_toy_accel;

   localparam int W = 2;

   logic         clk;
   logic         rst_n;
   logic         in_vld;
   logic         in_rdy;
   logic         action;
   logic [W-1:0] data;
   logic         out_vld;
   logic         out_rdy;
   logic [W-1:0] out;
   logic [W-1:0] arch_st;
   logic         busy;

   toy_accel #(.DATA_W(W), .OBUF_DEPTH(2)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_vld  (in_vld),
      .in_rdy  (in_rdy),
      .action  (action),
      .data    (data),
      .out_vld (out_vld),
      .out_rdy (out_rdy),
      .out     (out),
      .arch_st (arch_st),
      .busy    (busy)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int           n_vec = 0;
   int           n_err = 0;
   int           cyc   = 0;
   logic [W-1:0] exp_q[$];
   int           cyc_q[$];
   logic [W-1:0] got_q[$];
   logic [W-1:0] m_acc;
   bit           chk_lat;

   logic         s_in_rdy, s_out_vld, s_busy, s_acc_fire;
   logic [W-1:0] s_out, s_arch;

   task automatic check(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      cyc_q.delete();
      m_acc = '0;
   endtask

   // One clock: drive at negedge, sample before the next rising edge,
   // score any response pop and model any accepted command.
   task automatic step(input logic iv, input logic act, input logic [W-1:0] d,
                       input logic ordy);
      logic [W-1:0] e;
      int           a;
      @(negedge clk);
      in_vld  = iv;
      action  = act;
      data    = d;
      out_rdy = ordy;
      #1;
      s_in_rdy   = in_rdy;
      s_out_vld  = out_vld;
      s_out      = out;
      s_arch     = arch_st;
      s_busy     = busy;
      s_acc_fire = in_vld && in_rdy;
      if (out_vld && out_rdy) begin
         check("pop_implies_in_rdy", int'(in_rdy), 1);
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL spurious_resp: got %0d expected no response", out);
         end else begin
            e = exp_q.pop_front();
            a = cyc_q.pop_front();
            check("resp_value", int'(out), int'(e));
            if (chk_lat) check("resp_latency", cyc - (a + 1), 3);
            got_q.push_back(out);
         end
      end
      if (s_acc_fire) begin
         if (act) begin
            m_acc = d;
         end else begin
            e = d + m_acc;
            exp_q.push_back(e);
            cyc_q.push_back(cyc);
            m_acc = m_acc + 1'b1;
         end
      end
      cyc++;
   endtask

   task automatic drain();
      int n;
      n = 0;
      do begin
         step(1'b0, 1'b0, '0, 1'b1);
         n++;
      end while ((s_busy || exp_q.size() != 0) && n < 60);
      check("drain_idle", int'(s_busy), 0);
      check("drain_queue_empty", exp_q.size(), 0);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      in_vld = 1'b0; action = 1'b0; data = '0; out_rdy = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic         iv;
      logic         act;
      logic [W-1:0] d;
      logic         ordy;
      logic         e_in_rdy;
      logic         e_out_vld;
      logic [W-1:0] e_out;
      logic [W-1:0] e_arch;
   } vec_t;

   vec_t tbl[8];

   initial begin
      int n_acc;
      int n_pop;
      logic [W-1:0] want [4];

      // load 2, compute 1, compute 1 -> responses 3 then 0, acc 2,3,0
      tbl[0] = '{1, 1, 2, 1,  1, 0, 0, 0};
      tbl[1] = '{1, 0, 1, 1,  1, 0, 0, 0};
      tbl[2] = '{1, 0, 1, 1,  1, 0, 0, 0};
      tbl[3] = '{0, 0, 0, 1,  1, 0, 0, 0};
      tbl[4] = '{0, 0, 0, 1,  1, 0, 0, 2};
      tbl[5] = '{0, 0, 0, 1,  1, 1, 3, 3};
      tbl[6] = '{0, 0, 0, 1,  1, 1, 0, 0};
      tbl[7] = '{0, 0, 0, 1,  1, 0, 0, 0};

      rst_n = 1'b0;
      in_vld = 1'b0; action = 1'b0; data = '0; out_rdy = 1'b0;
      model_reset();
      chk_lat = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("reset_in_rdy", int'(in_rdy), 1);
      check("reset_out_vld", int'(out_vld), 0);
      check("reset_out", int'(out), 0);
      check("reset_arch_st", int'(arch_st), 0);
      check("reset_busy", int'(busy), 0);
      rst_n = 1'b1;

      chk_lat = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step(tbl[i].iv, tbl[i].act, tbl[i].d, tbl[i].ordy);
         check($sformatf("tbl%0d_in_rdy", i), int'(s_in_rdy), int'(tbl[i].e_in_rdy));
         check($sformatf("tbl%0d_out_vld", i), int'(s_out_vld), int'(tbl[i].e_out_vld));
         check($sformatf("tbl%0d_out", i), int'(s_out), int'(tbl[i].e_out));
         check($sformatf("tbl%0d_arch_st", i), int'(s_arch), int'(tbl[i].e_arch));
      end
      drain();

      // ---- backpressure: out_rdy low, offer 6 computes, exactly 5 fit ----
      apply_reset();
      chk_lat = 1'b0;
      n_acc = 0;
      for (int i = 0; i < 12; i++) begin
         step(1'b1, 1'b0, W'($urandom_range(0, 3)), 1'b0);
         if (s_acc_fire) n_acc++;
      end
      check("stall_accept_count", n_acc, 5);
      check("stall_in_rdy_low", int'(s_in_rdy), 0);
      check("stall_busy", int'(s_busy), 1);

      // ---- full buffer, 6th offered with out_rdy=1: pop+push same edge ----
      step(1'b1, 1'b0, 2'd1, 1'b1);
      check("full_pop_push_in_rdy", int'(s_in_rdy), 1);
      check("full_pop_push_accept", int'(s_acc_fire), 1);
      @(posedge clk);
      #1;
      check("full_pop_push_count", int'(dut.u_obuf.count), 2);

      got_q.delete();
      drain();
      check("stall_drain_count", got_q.size(), 5);

      // ---- load 1 with bubbles, then four compute data=0 -> 1,2,3,0 ----
      got_q.delete();
      step(1'b1, 1'b1, 2'd1, 1'b1);
      step(1'b0, 1'b0, 2'd3, 1'b1);
      step(1'b1, 1'b0, 2'd0, 1'b1);
      step(1'b0, 1'b1, 2'd2, 1'b1);
      step(1'b0, 1'b0, 2'd0, 1'b1);
      step(1'b1, 1'b0, 2'd0, 1'b1);
      step(1'b1, 1'b0, 2'd0, 1'b1);
      step(1'b0, 1'b0, 2'd1, 1'b1);
      step(1'b1, 1'b0, 2'd0, 1'b1);
      drain();
      want = '{2'd1, 2'd2, 2'd3, 2'd0};
      check("bubble_resp_count", got_q.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < got_q.size()) check($sformatf("bubble_resp%0d", i), int'(got_q[i]), int'(want[i]));
      end

      // ---- reset with 3 in flight and 2 buffered ----
      step(1'b1, 1'b1, 2'd3, 1'b0);
      n_acc = 0;
      for (int i = 0; i < 12 && n_acc < 5; i++) begin
         step(1'b1, 1'b0, W'($urandom_range(0, 3)), 1'b0);
         if (s_acc_fire) n_acc++;
      end
      step(1'b0, 1'b0, '0, 1'b0);
      check("pre_reset_full", int'(s_in_rdy), 0);
      check("pre_reset_arch_st", int'(s_arch), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_out_vld", int'(out_vld), 0);
      check("midrst_out", int'(out), 0);
      check("midrst_busy", int'(busy), 0);
      check("midrst_arch_st", int'(arch_st), 0);
      check("midrst_in_rdy", int'(in_rdy), 1);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      got_q.delete();
      chk_lat = 1'b1;
      step(1'b1, 1'b0, 2'd2, 1'b1);
      drain();
      check("post_reset_resp_count", got_q.size(), 1);
      if (got_q.size() > 0) check("post_reset_resp", int'(got_q[0]), 2);

      // ---- random traffic against the model ----
      chk_lat = 1'b0;
      n_pop = 0;
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
              W'($urandom_range(0, 3)), 1'($urandom_range(0, 9) < 6));
      end
      drain();
      check("random_final_arch_st", int'(arch_st), int'(m_acc));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_toy_accel
